instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder counterpart of the instruction decoder. Accepts decoded-style fields (opcode, funct,
//  rs/rt/rd, sa, imm, 26-bit target) over a valid/ready handshake and packs them into 32-bit MIPS words.
//  Writes each word into instruction memory at an auto-incrementing word address.
//  Used by the debug/program-load path to build a program before the pipeline is released.
// PARAMETERS
//  ADDR_W     8                  word-address width; DEPTH = 2**ADDR_W words
//  HALT_WORD  32'hFC00_0000      opcode 6'b111111; terminator word
// PORTS
//  i_clk        in   1       clock, rising edge
//  i_rst_n      in   1       asynchronous, active-low reset
//  i_valid      in   1       field bundle valid
//  o_ready      out  1       encoder can accept a bundle
//  i_kind       in   2       00 R-type, 01 I-type, 10 J-type, 11 reserved
//  i_opcode     in   6       opcode (ignored for R-type: forced 000000)
//  i_funct      in   6       R-type funct
//  i_rs/i_rt/i_rd in 5 each  register fields
//  i_sa         in   5       shift amount
//  i_imm        in   16      I-type immediate / branch offset
//  i_target     in   26      J-type target
//  i_finish     in   1       end of program
//  i_clear      in   1       restart load from address 0
//  o_mem_we     out  1       instruction-memory write strobe, one cycle per word
//  o_mem_addr   out  ADDR_W  word address
//  o_mem_data   out  32      encoded word
//  o_count      out  ADDR_W+1  words written so far
//  o_done / o_full / o_err  out 1 each  status flags (all sticky)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state IDLE; o_ready=1; o_mem_we=0; o_mem_addr=0; o_mem_data=0;
//    o_count=0; o_done=o_full=o_err=0. A write in flight is dropped: we deasserts immediately.
//  - Packing: R {6'b0,rs,rt,rd,sa,funct}; I {opcode,rs,rt,imm}; J {opcode,target}.
//  - Reserved kind: word discarded, no write, o_err set, state stays IDLE.
//  - FSM states IDLE, WRITE, FULL, DONE.
//    IDLE: o_ready=1. valid&ready at edge N latches the encoded word. WRITE is active in cycle N+1.
//    WRITE: o_ready=0; o_mem_we=1 for exactly one cycle with the current addr/data. At the end of
//      the cycle, addr and count increment. Next state: FULL if the written addr was DEPTH-1,
//      otherwise DONE if a finish is pending, otherwise IDLE.
//    FULL: o_ready=0, o_full=1. i_valid=1 sets o_err and the bundle is ignored.
//      i_finish moves the FSM to DONE (with HALT append if enabled and room exists; otherwise no append).
//    DONE: o_ready=0, o_done=1 until i_clear.
//  - i_finish in IDLE without i_valid: go to DONE (or append HALT, see below).
//  - i_valid & i_finish in the same cycle: valid has priority. The word is written, the finish is
//    latched as pending, and the FSM goes to DONE after WRITE.
//  - i_clear (any state, synchronous, priority over all except reset): addr=0, count=0, flags
//    cleared, state IDLE. Memory contents are untouched.
//  - Address wraps never; o_count saturates at DEPTH.
// CONFIGURATION
//  HALT_APPEND_EN defined: on finish, one extra WRITE of HALT_WORD at the next address precedes DONE.
//    It is counted in o_count. If the memory is full, HALT is skipped and o_err is set.
//  Not defined: finish goes straight to DONE; no terminator is written.
// STRUCTURE
//  Shared package: kind encodings (KIND_R/I/J/RSV), opcode constants (OP_RTYPE, OP_J, OP_JAL,
//    OP_BEQ, OP_BNE, OP_ADDI.., OP_LB.., OP_SB..), funct constants (FN_JR, FN_JALR), HALT_WORD.
//  Sub-module: instr_field_packer (combinational kind+fields -> 32-bit word, plus reserved flag).
//  Top: FSM, address/count registers, status flags.
// TESTING
//  1 R-type ADDU rs=1 rt=2 rd=3 sa=0 funct=100001 -> we one cycle after accept, addr 0, data 0x00221821.
//  2 I-type ADDI op=001000 rs=0 rt=5 imm=0x0010, then J op=000010 target=0x0000100 -> addr 0: 0x20050010,
//    addr 1: 0x08000100; o_count=2.
//  3 valid&finish in the same cycle with BEQ rs=1 rt=1 imm=0xFFFF -> word 0x1021FFFF written. With
//    HALT_APPEND_EN, 0xFC000000 follows at the next addr; then o_done=1, o_ready=0.
//  4 ADDR_W=2: five bundles -> four writes (addr 0..3), o_full=1, fifth valid sets o_err, no fifth we.
//  5 Kind=11 -> no we, o_err=1, o_ready stays 1. The next valid R-type is written at addr 0.
//  6 i_rst_n low during WRITE -> o_mem_we drops without waiting for a clock; all outputs at reset values.
//    i_clear in DONE -> IDLE, addr 0.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: field kinds, FSM states,
// MIPS opcode/funct constants and the program terminator word.
package instr_encoder_loader_pkg;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_I   = 2'b01,
    KIND_J   = 2'b10,
    KIND_RSV = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FULL  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [31:0] HALT_WORD = {OP_HALT, 26'd0};

endpackage

// File: rtl/instr_encoder_loader_field_packer.sv
// instr_field_packer: combinational packing of decoded-style fields into one
// 32-bit MIPS word; flags the reserved kind so the caller can drop it.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  sa_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        rsv_o
);

  always_comb begin
    word_o = '0;
    rsv_o  = 1'b0;
    case (kind_e'(kind_i))
      // R-type ignores the supplied opcode; the word always carries SPECIAL
      KIND_R:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, sa_i, funct_i};
      KIND_I:  word_o = {opcode_i, rs_i, rt_i, imm_i};
      KIND_J:  word_o = {opcode_i, target_i};
      default: rsv_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field bundles and writes them to instruction memory at
// auto-incrementing addresses. Optional terminator append via HALT_APPEND_EN.
module instr_encoder_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = instr_encoder_loader_pkg::HALT_WORD
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_kind,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_sa,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  input  logic              i_finish,
  input  logic              i_clear,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_done,
  output logic              o_full,
  output logic              o_err
);

  import instr_encoder_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       data_q, data_d;
  logic              fin_pend_q, fin_pend_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              go_finish;
  logic [31:0]       pk_word;
  logic              pk_rsv;

  instr_field_packer u_packer (
    .kind_i   (i_kind),
    .opcode_i (i_opcode),
    .funct_i  (i_funct),
    .rs_i     (i_rs),
    .rt_i     (i_rt),
    .rd_i     (i_rd),
    .sa_i     (i_sa),
    .imm_i    (i_imm),
    .target_i (i_target),
    .word_o   (pk_word),
    .rsv_o    (pk_rsv)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      fin_pend_q <= 1'b0;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      fin_pend_q <= fin_pend_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    data_d     = data_q;
    fin_pend_d = fin_pend_q;
    halt_d     = halt_q;
    done_d     = done_q;
    full_d     = full_q;
    err_d      = err_q;
    go_finish  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (pk_rsv) begin
            // reserved bundle is dropped; a finish riding with it still closes the program
            err_d     = 1'b1;
            go_finish = i_finish;
          end else begin
            data_d     = pk_word;
            fin_pend_d = i_finish;
            state_d    = ST_WRITE;
          end
        end else if (i_finish) begin
          go_finish = 1'b1;
        end
      end

      ST_WRITE: begin
        if (count_q != DEPTH_CNT) count_d = count_q + 1'b1;
        if (addr_q != LAST_ADDR)  addr_d  = addr_q + 1'b1;
        if (halt_q) begin
          halt_d  = 1'b0;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_FULL;
          full_d  = 1'b1;
        end else if (fin_pend_q) begin
          fin_pend_d = 1'b0;
          go_finish  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FULL: begin
        if (i_valid) err_d = 1'b1;
        if (i_finish || fin_pend_q) begin
          fin_pend_d = 1'b0;
          state_d    = ST_DONE;
          done_d     = 1'b1;
`ifdef HALT_APPEND_EN
          err_d      = 1'b1;
`endif
        end
      end

      default: ;
    endcase

    if (go_finish) begin
      // data bus parks on the terminator once the program is closed
      data_d = HALT_WORD;
`ifdef HALT_APPEND_EN
      halt_d  = 1'b1;
      state_d = ST_WRITE;
`else
      state_d = ST_DONE;
      done_d  = 1'b1;
`endif
    end

    if (i_clear) begin
      state_d    = ST_IDLE;
      addr_d     = '0;
      count_d    = '0;
      fin_pend_d = 1'b0;
      halt_d     = 1'b0;
      done_d     = 1'b0;
      full_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_mem_we   = (state_q == ST_WRITE);
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
  assign o_count    = count_q;
  assign o_done     = done_q;
  assign o_full     = full_q;
  assign o_err      = err_q;

endmodule
